// File: rtl/hvgen_pkg.sv
// Shared timing constants and active-width mode table for the raster generator.
package hvgen_pkg;

    localparam int MODE_W = 2;
    localparam int CNT_W  = 9;
    localparam int TRIM_W = 4;

    localparam int HTOTAL_DEF   = 320;
    localparam int VTOTAL_DEF   = 260;
    localparam int VACT_DEF     = 224;
    localparam int HPOS_OFS_DEF = 16;
    localparam int HS_START_DEF = 296;
    localparam int HS_LEN_DEF   = 16;
    localparam int VS_START_DEF = 234;
    localparam int VS_LEN_DEF   = 4;

    typedef logic [CNT_W-1:0]         cnt_t;
    typedef logic [MODE_W-1:0]        mode_t;
    typedef logic signed [TRIM_W-1:0] trim_t;

    // Horizontal blank ends at hb_end and restarts at hb_start for each mode.
    function automatic cnt_t hb_end(input mode_t m);
        case (m)
            2'd0:    hb_end = 9'd30;
            2'd1:    hb_end = 9'd38;
            2'd2:    hb_end = 9'd46;
            default: hb_end = 9'd62;
        endcase
    endfunction

    function automatic cnt_t hb_start(input mode_t m);
        case (m)
            2'd0:    hb_start = 9'd286;
            2'd1:    hb_start = 9'd278;
            2'd2:    hb_start = 9'd270;
            default: hb_start = 9'd254;
        endcase
    endfunction

endpackage

// File: rtl/hvgen_win.sv
// Registered in-window comparator: flags cnt in [START+trim, START+trim+LEN), 9-bit modular.
module hvgen_win
    import hvgen_pkg::*;
#(
    parameter int START = 0,
    parameter int LEN   = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  cnt_t  cnt,
    input  trim_t trim,
    output logic  in_win
);

    cnt_t lo;
    cnt_t hi;
    logic in_win_d;
    logic in_win_q;

    // Bounds wrap mod 512 with a plain unsigned compare, so a wrapped window simply never matches.
    always_comb begin
        lo       = cnt_t'(START) + {{(CNT_W-TRIM_W){trim[TRIM_W-1]}}, trim};
        hi       = lo + cnt_t'(LEN);
        in_win_d = in_win_q;
        if (en) begin
            in_win_d = (cnt >= lo) && (cnt < hi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_win_q <= 1'b0;
        end else begin
            in_win_q <= in_win_d;
        end
    end

    assign in_win = in_win_q;

endmodule

// File: rtl/hvgen_param.sv
// Parameterised H/V raster timing generator with frame-aligned mode/trim updates and blank gating.
module hvgen_param
    import hvgen_pkg::*;
#(
    parameter int HTOTAL   = HTOTAL_DEF,
    parameter int VTOTAL   = VTOTAL_DEF,
    parameter int VACT     = VACT_DEF,
    parameter int HPOS_OFS = HPOS_OFS_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_LEN   = HS_LEN_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_LEN   = VS_LEN_DEF,
    parameter int RGB_W    = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PCLK_EN,
    input  mode_t            MODE,
    input  trim_t            HOFFS,
    input  trim_t            VOFFS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [8:0]       HPOS,
    output logic [8:0]       VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             VBL_IRQ,
    output logic             FIELD,
    output mode_t            MODE_ACT
);

    cnt_t             hcnt_q, hcnt_d;
    cnt_t             vcnt_q, vcnt_d;
    mode_t            mode_q, mode_d;
    trim_t            hoffs_q, hoffs_d;
    trim_t            voffs_q, voffs_d;
    logic             hblk_q, hblk_d;
    logic             vblk_q, vblk_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             irq_q, irq_d;
    logic             field_q, field_d;
    logic             h_last;
    logic             v_last;
    logic             frame_end;
    logic             hs_win;
    logic             vs_win;

    always_comb begin
        h_last    = (hcnt_q == cnt_t'(HTOTAL - 1));
        v_last    = (vcnt_q == cnt_t'(VTOTAL - 1));
        frame_end = PCLK_EN && h_last && v_last;

        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        mode_d  = mode_q;
        hoffs_d = hoffs_q;
        voffs_d = voffs_q;
        hblk_d  = hblk_q;
        vblk_d  = vblk_q;
        rgb_d   = rgb_q;
        field_d = field_q;
        irq_d   = 1'b0;

        if (PCLK_EN) begin
            hcnt_d = h_last ? '0 : hcnt_q + 9'd1;
            if (h_last) begin
                vcnt_d = v_last ? '0 : vcnt_q + 9'd1;
            end
            hblk_d = (hcnt_q < hb_end(mode_q)) || (hcnt_q >= hb_start(mode_q));
            vblk_d = (vcnt_q >= cnt_t'(VACT));
            // Gate on the blanks already on the outputs, not the ones being computed now.
            rgb_d  = (hblk_q || vblk_q) ? '0 : iRGB;
            irq_d  = vblk_d && !vblk_q;
            if (frame_end) begin
                field_d = ~field_q;
                mode_d  = MODE;
                hoffs_d = HOFFS;
                voffs_d = VOFFS;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            mode_q  <= MODE;
            hoffs_q <= HOFFS;
            voffs_q <= VOFFS;
            hblk_q  <= 1'b1;
            vblk_q  <= 1'b1;
            rgb_q   <= '0;
            irq_q   <= 1'b0;
            field_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            mode_q  <= mode_d;
            hoffs_q <= hoffs_d;
            voffs_q <= voffs_d;
            hblk_q  <= hblk_d;
            vblk_q  <= vblk_d;
            rgb_q   <= rgb_d;
            irq_q   <= irq_d;
            field_q <= field_d;
        end
    end

    hvgen_win #(
        .START (HS_START),
        .LEN   (HS_LEN)
    ) u_hs_win (
        .clk    (CLK),
        .rst    (RESET),
        .en     (PCLK_EN),
        .cnt    (hcnt_q),
        .trim   (hoffs_q),
        .in_win (hs_win)
    );

    hvgen_win #(
        .START (VS_START),
        .LEN   (VS_LEN)
    ) u_vs_win (
        .clk    (CLK),
        .rst    (RESET),
        .en     (PCLK_EN),
        .cnt    (vcnt_q),
        .trim   (voffs_q),
        .in_win (vs_win)
    );

    assign HPOS     = hcnt_q - cnt_t'(HPOS_OFS);
    assign VPOS     = vcnt_q;
    assign oRGB     = rgb_q;
    assign HBLK     = hblk_q;
    assign VBLK     = vblk_q;
    assign HSYN     = ~hs_win;
    assign VSYN     = ~vs_win;
    assign VBL_IRQ  = irq_q;
    assign FIELD    = field_q;
    assign MODE_ACT = mode_q;

endmodule

// File: tb/tb_hvgen_param.sv
// Directed bench for hvgen_param; a shortened frame (20 lines) keeps full-frame runs cheap.
module tb_hvgen_param;

    localparam int HT  = 320;
    localparam int VT  = 20;
    localparam int VA  = 12;
    localparam int VSS = 14;
    localparam int VSL = 2;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                PCLK_EN = 1'b0;
    logic [1:0]          MODE = 2'd0;
    logic signed [3:0]   HOFFS = 4'sd0;
    logic signed [3:0]   VOFFS = 4'sd0;
    logic [11:0]         iRGB = 12'h000;
    logic [8:0]          HPOS;
    logic [8:0]          VPOS;
    logic [11:0]         oRGB;
    logic                HBLK, VBLK, HSYN, VSYN, VBL_IRQ, FIELD;
    logic [1:0]          MODE_ACT;

    hvgen_param #(
        .VTOTAL   (VT),
        .VACT     (VA),
        .VS_START (VSS),
        .VS_LEN   (VSL)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PCLK_EN  (PCLK_EN),
        .MODE     (MODE),
        .HOFFS    (HOFFS),
        .VOFFS    (VOFFS),
        .iRGB     (iRGB),
        .HPOS     (HPOS),
        .VPOS     (VPOS),
        .oRGB     (oRGB),
        .HBLK     (HBLK),
        .VBLK     (VBLK),
        .HSYN     (HSYN),
        .VSYN     (VSYN),
        .VBL_IRQ  (VBL_IRQ),
        .FIELD    (FIELD),
        .MODE_ACT (MODE_ACT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int hc, vc, m_exp, ho_exp, vo_exp;
    int irq_seen;
    int hbe [4] = '{30, 38, 46, 62};
    int hbs [4] = '{286, 278, 270, 254};
    logic e_hblk, e_vblk, e_hsyn, e_vsyn, e_irq, e_field;
    logic [11:0] e_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (hc=%0d vc=%0d)", tag, obs, exp, hc, vc);
        end
    endtask

    task automatic chk_all();
        chk("HPOS", 32'(HPOS), 32'((hc - 16) & 511));
        chk("VPOS", 32'(VPOS), 32'(vc));
        chk("HBLK", 32'(HBLK), 32'(e_hblk));
        chk("VBLK", 32'(VBLK), 32'(e_vblk));
        chk("HSYN", 32'(HSYN), 32'(e_hsyn));
        chk("VSYN", 32'(VSYN), 32'(e_vsyn));
        chk("oRGB", 32'(oRGB), 32'(e_rgb));
        chk("VBL_IRQ", 32'(VBL_IRQ), 32'(e_irq));
        chk("FIELD", 32'(FIELD), 32'(e_field));
        chk("MODE_ACT", 32'(MODE_ACT), 32'(m_exp));
        if (VBL_IRQ === 1'b1) irq_seen++;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic signed [3:0] ho, input logic signed [3:0] vo);
        MODE = m;
        HOFFS = ho;
        VOFFS = vo;
        RESET = 1'b1;
        PCLK_EN = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        hc = 0; vc = 0;
        m_exp = int'(m); ho_exp = int'(ho); vo_exp = int'(vo);
        e_hblk = 1'b1; e_vblk = 1'b1; e_hsyn = 1'b1; e_vsyn = 1'b1;
        e_rgb = 12'h000; e_irq = 1'b0; e_field = 1'b0;
        chk_all();
    endtask

    task automatic tick();
        logic hb, vb, hs, vs, old_blk, old_vb;
        int hlo, vlo;
        PCLK_EN = 1'b1;
        @(posedge CLK);
        #1;
        old_blk = e_hblk | e_vblk;
        old_vb  = e_vblk;
        hlo = 296 + ho_exp;
        vlo = VSS + vo_exp;
        hb = (hc < hbe[m_exp]) || (hc >= hbs[m_exp]);
        vb = (vc >= VA);
        hs = (hc >= hlo) && (hc < hlo + 16);
        vs = (vc >= vlo) && (vc < vlo + VSL);
        e_hblk = hb;
        e_vblk = vb;
        e_hsyn = !hs;
        e_vsyn = !vs;
        e_rgb  = old_blk ? 12'h000 : iRGB;
        e_irq  = vb && !old_vb;
        if (hc == HT - 1 && vc == VT - 1) begin
            e_field = !e_field;
            m_exp   = int'(MODE);
            ho_exp  = int'(HOFFS);
            vo_exp  = int'(VOFFS);
        end
        hc++;
        if (hc == HT) begin
            hc = 0;
            vc++;
            if (vc == VT) vc = 0;
        end
        chk_all();
    endtask

    task automatic idle(input int n);
        PCLK_EN = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
            e_irq = 1'b0;
            chk_all();
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;

        // Nominal frame, mode 0, zero trim, constant white pixels.
        iRGB = 12'hFFF;
        do_reset(2'd0, 4'sd0, 4'sd0);
        chk("rst_HPOS", 32'(HPOS), 32'd496);
        irq_seen = 0;
        repeat (HT * VT) tick();
        chk("A_irq_count", 32'(irq_seen), 32'd1);
        chk("A_field", 32'(FIELD), 32'd1);

        // Mid-frame mode/trim change takes effect only at the next frame boundary.
        repeat (HT * 5) tick();
        MODE = 2'd1;
        HOFFS = 4'sd5;
        for (int k = 0; k < HT * VT && !(hc == 0 && vc == 0); k++) tick();
        chk("B_mode_act", 32'(MODE_ACT), 32'd1);
        chk("B_field", 32'(FIELD), 32'd0);
        repeat (HT * 2) tick();

        // Trim loaded at reset: HSYN 288..303, VSYN lines 17..18.
        iRGB = 12'h5A3;
        do_reset(2'd2, -4'sd8, 4'sd3);
        irq_seen = 0;
        repeat (HT * VT) tick();
        chk("C_irq_count", 32'(irq_seen), 32'd1);

        // Reset mid-frame at hcnt=150, line 5.
        repeat (HT * 5 + 150) tick();
        chk("E_pre_HPOS", 32'(HPOS), 32'd134);
        do_reset(2'd3, 4'sd0, 4'sd0);
        chk("E_VPOS", 32'(VPOS), 32'd0);
        chk("E_HBLK", 32'(HBLK), 32'd1);
        chk("E_oRGB", 32'(oRGB), 32'd0);

        // Pixel enable 1-in-4: one single-cycle IRQ per frame.
        irq_seen = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            idle(3);
        end
        chk("D_irq_count", 32'(irq_seen), 32'd1);
        chk("D_field", 32'(FIELD), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hvgen_param.md
HVGEN_PARAM -- requirements
Module: hvgen_param

Interface
REQ-001 Parameter HTOTAL, default 320, pixels per line including blanking.
REQ-002 Parameter VTOTAL, default 260, lines per frame.
REQ-003 Parameter VACT, default 224, active lines; VBLK asserted for vcnt >= VACT.
REQ-004 Parameter HPOS_OFS, default 16, subtracted from hcnt to form HPOS.
REQ-005 Parameters HS_START 296, HS_LEN 16, VS_START 234, VS_LEN 4, nominal sync start and length in counter units.
REQ-006 Parameter RGB_W, default 12, pixel data width.
REQ-007 CLK  in  1  system clock, all logic on rising edge.
REQ-008 RESET  in  1  one clock; reset is synchronous and active-high.
REQ-009 PCLK_EN  in  1  pixel-clock enable; all state except IRQ clearing advances only when high.
REQ-010 MODE  in  2  requested active-width mode, index into the package mode table.
REQ-011 HOFFS, VOFFS  in  4 each, signed  sync position trim.
REQ-012 iRGB  in  RGB_W  pixel from the renderer.
REQ-013 HPOS, VPOS  out  9 each  hcnt-HPOS_OFS (mod 512), vcnt.
REQ-014 oRGB  out  RGB_W  blank-gated registered pixel.
REQ-015 HBLK, VBLK, HSYN, VSYN  out  1 each  blanks active-high, syncs active-low.
REQ-016 VBL_IRQ  out  1  one-CLK pulse at vertical blank start.
REQ-017 FIELD  out  1  toggles once per frame.
REQ-018 MODE_ACT  out  2  mode currently applied.

Function
REQ-019 On a PCLK_EN cycle, hcnt SHALL increment, wrap HTOTAL-1 -> 0, and vcnt SHALL increment on that wrap, wrapping VTOTAL-1 -> 0.
REQ-020 Frame boundary SHALL be the PCLK_EN cycle with hcnt=HTOTAL-1 and vcnt=VTOTAL-1.
REQ-021 MODE, HOFFS, VOFFS SHALL be sampled into active registers only at a frame boundary; mid-frame changes have no effect until then.
REQ-022 HBLK SHALL register (hcnt < HB_END[m]) | (hcnt >= HB_START[m]) for active mode m, one PCLK_EN tick after the counter value.
REQ-023 Mode table: m0 30/286 (256 px), m1 38/278 (240 px), m2 46/270 (224 px), m3 62/254 (192 px).
REQ-024 VBLK SHALL register (vcnt >= VACT) with the same one-tick latency.
REQ-025 HSYN SHALL be low for hcnt in [HS_START+HOFFS, HS_START+HOFFS+HS_LEN), 9-bit modular sums, comparison unsigned; VSYN likewise with VS_START, VOFFS, VS_LEN.
REQ-026 Sync window wrapping past 511 SHALL follow the unsigned compare (no special wrap handling); parameters SHALL keep windows inside 0..HTOTAL-1.
REQ-027 oRGB SHALL register 0 when the current registered HBLK or VBLK is high, else iRGB.
REQ-028 VBL_IRQ SHALL be high for exactly one CLK cycle, the cycle after the PCLK_EN tick in which VBLK rises 0->1; never asserted twice per frame.
REQ-029 FIELD SHALL toggle on every frame boundary.
REQ-030 With PCLK_EN low, all outputs SHALL hold except VBL_IRQ, which SHALL clear.

Reset
REQ-031 During RESET: hcnt=0, vcnt=0, HBLK=1, VBLK=1, HSYN=1, VSYN=1, oRGB=0, VBL_IRQ=0, FIELD=0.
REQ-032 During RESET, active mode and offsets SHALL load directly from MODE, HOFFS, VOFFS.
REQ-033 RESET SHALL override PCLK_EN and take effect mid-frame on the next edge.

Structure
REQ-034 Shared package hvgen_pkg SHALL hold the mode table constants (HB_END, HB_START per mode), mode width (2) and default timing constants.
REQ-035 One sub-module, hvgen_win (registered in-window comparator with start, length, signed trim), SHALL be instantiated for HSYN and VSYN.

Verification
REQ-036 Reset, PCLK_EN=1, MODE=0, offsets 0: HBLK low hcnt 30..285 (registered), HSYN low hcnt 296..311, VSYN low lines 234..237, 320x260 ticks per frame.
REQ-037 MODE 0->1 at line 100: HBLK window unchanged until boundary, next frame active 38..277, MODE_ACT=1 from boundary.
REQ-038 HOFFS=-8, VOFFS=+3 set at reset: HSYN low 288..303, VSYN low 237..240.
REQ-039 PCLK_EN toggling 1-in-4: counters advance per enable only; VBL_IRQ single CLK-wide pulse per frame at line 224 start.
REQ-040 RESET asserted at hcnt=150, vcnt=100: next cycle counters 0, blanks/syncs 1, oRGB 0, FIELD 0.
REQ-041 iRGB=12'hFFF constant: oRGB zero in every blanked pixel, FFF elsewhere; FIELD toggles each frame.
